// File: rtl/parity_word_rx_if.sv
// Serial-in / checked-word-out handshake bundle for parity_word_rx.
// The slave side is the receiver; the master side is the link plus the consumer.
interface parity_word_rx_if #(
  parameter int WORD_W = 32
);
  logic              bit_valid;
  logic              bit_in;
  logic              judge;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_word;
  logic [WORD_W-2:0] out_payload;
  logic              out_err;

  modport master (
    output bit_valid, bit_in, judge, out_ready,
    input  out_valid, out_word, out_payload, out_err
  );

  modport slave (
    input  bit_valid, bit_in, judge, out_ready,
    output out_valid, out_word, out_payload, out_err
  );
endinterface

// File: rtl/parity_word_rx.sv
// LSB-first deserialiser that checks the MSB parity bit of each word and
// hands the word to a one-entry valid/ready output register with statistics.
module parity_word_rx #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parity_word_rx_if.slave      rx,
  input  logic                 clear,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [15:0]          word_cnt,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BCNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  function automatic logic parity_err(input logic [WORD_W-1:0] w, input logic judge_bit);
    return (^w) ^ judge_bit;
  endfunction

  // The bit that would sit at sreg[0] is always shifted out before it is
  // observed, so only the upper WORD_W-1 bits of the window are stored.
  logic [WORD_W-2:0] sreg_q, sreg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              overrun_q, overrun_d;

  logic              word_done;
  logic [WORD_W-1:0] word_w;
  logic              word_err;
  logic              load;
  logic              drop;
  logic              pop;

  always_comb begin
    word_w    = {rx.bit_in, sreg_q};
    word_done = rx.bit_valid && (bcnt_q == LAST_BIT);
    word_err  = parity_err(word_w, rx.judge);
    load      = word_done && (!out_valid_q || rx.out_ready);
    drop      = word_done && out_valid_q && !rx.out_ready;
    pop       = out_valid_q && rx.out_ready && !word_done;

    sreg_d      = sreg_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    overrun_d   = overrun_q;

    if (rx.bit_valid) begin
      sreg_d = word_w[WORD_W-1:1];
      bcnt_d = word_done ? '0 : bcnt_q + BCNT_W'(1);
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_word_d  = word_w;
      out_err_d   = word_err;
      word_cnt_d  = word_cnt_q + 16'd1;
      if (word_err) err_cnt_d = sat_inc(err_cnt_q);
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (drop) overrun_d = 1'b1;

    // Clear wins over any same-cycle statistic update.
    if (clear) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q      <= '0;
      bcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx.out_valid   = out_valid_q;
  assign rx.out_word    = out_word_q;
  assign rx.out_payload = out_word_q[WORD_W-2:0];
  assign rx.out_err     = out_err_q;
  assign err_cnt        = err_cnt_q;
  assign word_cnt       = word_cnt_q;
  assign overrun        = overrun_q;
  assign busy           = (bcnt_q != '0);
endmodule

// File: tb/tb_parity_word_rx.sv
// Randomised self-checking bench for parity_word_rx against a word-level
// reference model (bit accumulation by arithmetic, parity by popcount).
module tb_parity_word_rx;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [CNT_W-1:0] err_cnt;
  logic [15:0]      word_cnt;
  logic             overrun;
  logic             busy;

  parity_word_rx_if #(.WORD_W(WORD_W)) rx_if ();

  parity_word_rx #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx_if.slave),
    .clear    (clear),
    .err_cnt  (err_cnt),
    .word_cnt (word_cnt),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_n;
  logic [31:0] m_acc;
  logic        m_valid;
  logic [31:0] m_word;
  logic        m_err;
  int          m_ecnt;
  logic [15:0] m_wcnt;
  logic        m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_acc = '0; m_valid = 1'b0; m_word = '0; m_err = 1'b0;
    m_ecnt = 0; m_wcnt = '0; m_ovr = 1'b0;
  endtask

  task automatic check_all(input string where);
    check_eq({where, ".out_valid"},   32'(rx_if.out_valid),   32'(m_valid));
    check_eq({where, ".out_word"},    rx_if.out_word,         m_word);
    check_eq({where, ".out_payload"}, 32'(rx_if.out_payload), m_word & 32'h7FFF_FFFF);
    check_eq({where, ".out_err"},     32'(rx_if.out_err),     32'(m_err));
    check_eq({where, ".err_cnt"},     32'(err_cnt),           32'(m_ecnt));
    check_eq({where, ".word_cnt"},    32'(word_cnt),          32'(m_wcnt));
    check_eq({where, ".overrun"},     32'(overrun),           32'(m_ovr));
    check_eq({where, ".busy"},        32'(busy),              32'(m_n != 0));
  endtask

  // Apply inputs, clock once, advance the model and compare everything.
  task automatic cycle(input logic bv, input logic b, input logic j, input logic rdy, input logic clr);
    logic        done;
    logic [31:0] w;
    logic        e;
    rx_if.bit_valid = bv;
    rx_if.bit_in    = b;
    rx_if.judge     = j;
    rx_if.out_ready = rdy;
    clear           = clr;
    @(posedge clk);
    done = bv && (m_n == WORD_W - 1);
    if (done) begin
      w = m_acc | (32'(b) << (WORD_W - 1));
      e = (($countones(w) % 2) == 1) != j;
      m_n = 0;
      m_acc = '0;
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_word  = w;
        m_err   = e;
        m_wcnt  = m_wcnt + 16'd1;
        if (e && m_ecnt < (1 << CNT_W) - 1) m_ecnt++;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (bv) begin
        m_acc = m_acc | (32'(b) << m_n);
        m_n++;
      end
      if (m_valid && rdy) m_valid = 1'b0;
    end
    if (clr) begin
      m_ecnt = 0;
      m_wcnt = '0;
      m_ovr  = 1'b0;
    end
    #1;
    check_all("cyc");
  endtask

  task automatic send_word(input logic [31:0] w, input logic j, input logic rdy_body,
                           input logic rdy_last, input bit gaps, input bit rnd);
    logic r;
    int   ng;
    for (int i = 0; i < WORD_W; i++) begin
      if (gaps) begin
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++)
          cycle(1'b0, 1'($urandom), j, rnd ? 1'($urandom) : rdy_body,
                rnd && ($urandom_range(0, 80) == 0));
      end
      r = (i == WORD_W - 1) ? rdy_last : rdy_body;
      if (rnd) r = 1'($urandom);
      cycle(1'b1, w[i], j, r, rnd && ($urandom_range(0, 80) == 0));
    end
  endtask

  task automatic do_reset();
    rx_if.bit_valid = 1'b0;
    rx_if.out_ready = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all("rst");
    #1;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    rx_if.bit_valid = 1'b0;
    rx_if.bit_in    = 1'b0;
    rx_if.judge     = 1'b0;
    rx_if.out_ready = 1'b0;
    model_reset();
    #12;
    check_all("por");
    check_eq("por_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // even mode, correct word
    send_word(32'h0000_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("even_valid", 32'(rx_if.out_valid), 32'd1);
    check_eq("even_word", rx_if.out_word, 32'h0000_0003);
    check_eq("even_err", 32'(rx_if.out_err), 32'd0);
    check_eq("even_wcnt", 32'(word_cnt), 32'd1);
    check_eq("even_ecnt", 32'(err_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("even_pop", 32'(rx_if.out_valid), 32'd0);

    // odd mode, both parity values
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(32'h8000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("odd_ok_err", 32'(rx_if.out_err), 32'd0);
    send_word(32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("odd_bad_err", 32'(rx_if.out_err), 32'd1);
    check_eq("odd_bad_ecnt", 32'(err_cnt), 32'd1);
    check_eq("odd_bad_wcnt", 32'(word_cnt), 32'd2);

    // gapped stream
    send_word(32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("gap_word", rx_if.out_word, 32'hFFFF_FFFE);
    check_eq("gap_err", 32'(rx_if.out_err), 32'd0);

    // reset in the middle of a word
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    do_reset();
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(rx_if.out_valid), 32'd0);
    send_word(32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fresh_word", rx_if.out_word, 32'h0000_00A5);
    check_eq("fresh_err", 32'(rx_if.out_err), 32'd0);
    check_eq("fresh_wcnt", 32'(word_cnt), 32'd1);

    // backpressure and overrun
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovr_word", rx_if.out_word, 32'h0000_0000);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_wcnt", 32'(word_cnt), 32'd1);
    check_eq("ovr_ecnt", 32'(err_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovr_pop", 32'(rx_if.out_valid), 32'd0);
    send_word(32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pushpop_valid", 32'(rx_if.out_valid), 32'd1);
    check_eq("pushpop_word", rx_if.out_word, 32'h0000_0012);
    check_eq("pushpop_wcnt", 32'(word_cnt), 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // error counter saturation, then clear
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 256; k++)
      send_word(32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sat_ecnt", 32'(err_cnt), 32'h0000_00FF);
    check_eq("sat_wcnt", 32'(word_cnt), 32'd256);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_ecnt", 32'(err_cnt), 32'd0);
    check_eq("clr_wcnt", 32'(word_cnt), 32'd0);
    check_eq("clr_ovr", 32'(overrun), 32'd0);
    check_eq("clr_word", rx_if.out_word, 32'h0000_0001);

    // randomised traffic: random words, judge, gaps, ready and clear
    for (int k = 0; k < 60; k++)
      send_word($urandom, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/parity_word_rx.md
Name: parity_word_rx

Overview:
- Receive-side counterpart of the 32-bit parity-word generator.
- Bit 31 of each word is a parity bit over bits 30:0. The polarity is chosen by judge: judge=1 means odd total ones, judge=0 means even total ones.
- The block deserialises a bit stream LSB-first into words and checks each word's parity.
- Each checked word is presented through a one-entry valid/ready output register with an error flag. The block keeps error and word statistics.
- It sits between a serial link and the consumer of checked payloads.

Parameters:
- WORD_W, 32, word width including the parity bit at MSB (must be >=2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- judge  input  1  parity mode, sampled on the cycle the final bit of a word is accepted (1 = odd total ones, 0 = even total ones).
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit, LSB first.
- clear  input  1  synchronous clear of err_cnt, word_cnt and overrun.
- out_ready  input  1  consumer accepts the output word this cycle.
- out_valid  output  1  output register holds an unconsumed word.
- out_word  output  WORD_W  full received word including the parity bit.
- out_payload  output  WORD_W-1  out_word[WORD_W-2:0].
- out_err  output  1  parity mismatch for the word in out_word.
- err_cnt  output  CNT_W  count of accepted words with out_err=1; saturates at all-ones.
- word_cnt  output  16  count of words loaded into the output register; wraps modulo 2^16.
- overrun  output  1  sticky flag: a completed word was dropped.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (async, asserts immediately): shift register=0, bit count=0, out_valid=0, out_word=0, out_err=0, err_cnt=0, word_cnt=0, overrun=0, busy=0. A partial word in progress is discarded.
- States:
  - RECV: bit count 0..WORD_W-1.
  - Output register: EMPTY or FULL, reported by out_valid.
- Shift: on bit_valid=1, sreg <= {bit_in, sreg[WORD_W-1:1]} and count increments. Cycles with bit_valid=0 hold all state, so gaps inside a word are allowed.
- Completion: bit_valid=1 with count==WORD_W-1.
  - Completed word w = {bit_in, sreg[WORD_W-1:1]}.
  - err = (^w) ^ judge, i.e. error when the XOR of all WORD_W bits differs from judge.
  - Count returns to 0 in the same edge.
- Load rule: the completed word loads into the output register when out_valid=0, or when out_valid=1 and out_ready=1 (simultaneous pop and push).
  - On load: out_word<=w, out_err<=err, out_valid<=1, word_cnt+1, err_cnt+1 if err and not saturated.
  - Latency: out_valid rises on the clock edge that accepts the final bit, so it is visible the cycle after.
- Overrun: completion while out_valid=1 and out_ready=0.
  - Word is dropped; out_word/out_err are unchanged.
  - overrun<=1; counters are unchanged.
  - Shifting of the next word proceeds normally.
- Pop: out_valid=1, out_ready=1 and no completion in the same cycle gives out_valid<=0. out_word and out_err hold their last value.
- out_ready while out_valid=0 is ignored.
- clear=1: err_cnt<=0, word_cnt<=0, overrun<=0.
  - clear has priority over a same-cycle increment or overrun set.
  - clear does not affect the shifter or the output register.
- busy = (count != 0), combinational from the registered count.
- All outputs are driven from registers except out_payload (a slice) and busy.

Test Plan:
- Even mode, correct word: stream 0x00000003 LSB-first with judge=0, out_ready=1 -> out_valid pulses 1 cycle after bit 31; out_word=0x00000003, out_err=0, word_cnt=1, err_cnt=0.
- Odd mode, both parity values:
  - Stream 0x80000003 with judge=1 -> out_err=0.
  - Then stream 0x00000003 with judge=1 -> out_err=1, err_cnt=1, word_cnt=2.
- Gapped bits plus reset mid-word:
  - Insert bit_valid=0 gaps in a 0xFFFFFFFE (judge=1) stream -> same result as ungapped: out_err=0, busy=1 during the word.
  - Assert reset after 10 bits -> busy=0, no word produced, and the next 32 bits form a fresh word.
- Backpressure and overrun:
  - Hold out_ready=0 and send word A=0x00000000 then word B=0x80000000 with judge=0 -> out_word stays A, overrun=1, word_cnt=1.
  - Raise out_ready -> out_valid falls.
  - Pop in the same cycle as the next completion -> out_valid stays 1 and the new word appears.
- Saturation and clear:
  - Send 256 bad words (0x00000001, judge=0) -> err_cnt sticks at 0xFF, word_cnt=256.
  - Pulse clear -> err_cnt=0, word_cnt=0, overrun=0; out_word is unchanged.
